fifo_rr_arbiter: RTL
====================

// Module: fifo_rr_arbiter
// PURPOSE
//  Round-robin scheduler that drains N_REQ source FIFOs into one destination FIFO, one word/cycle.
//  Drives source read_enable (src_pop) and destination write_enable (dst_push) from FIFO flags.
//  Applies backpressure on destination almost_full/full; fatal error latches ERROR.
//  Sits between per-lane FIFOs and the shared downstream FIFO.
// PARAMETERS
//  DATA_W   10  word width of every FIFO
//  N_REQ    4   number of source FIFOs (>=2)
//  ID_W     2   width of grant index, must be >= clog2(N_REQ)
// PORTS
//  clk          in   1              rising-edge clock
//  reset        in   1              synchronous, active-high reset
//  init         in   1              request return to INIT (pause scheduling)
//  src_mask     in   N_REQ          1 = source eligible for grant
//  src_empty    in   N_REQ          source FIFO empty flags
//  src_error    in   N_REQ          source FIFO error flags
//  src_data     in   N_REQ*DATA_W   source data_out, source i at [i*DATA_W +: DATA_W]
//  src_pop      out  N_REQ          one-hot read_enable to sources (registered)
//  dst_full     in   1              destination full
//  dst_afull    in   1              destination almost_full
//  dst_error    in   1              destination error
//  dst_push     out  1              write_enable to destination (registered)
//  dst_data     out  DATA_W         data_in to destination
//  grant_id     out  ID_W           index of source popped in previous cycle
//  state        out  3              FSM state encoding
//  idle, error_out out 1 each       state==IDLE, state==ERROR
// BEHAVIOUR
//  Reset (reset=1 at posedge): src_pop=0, dst_push=0, grant_id=0, rr_ptr=N_REQ-1, state=RESET.
//   dst_data = src_data slice of grant_id (combinational mux) -> source 0 after reset.
//  States: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
//   RESET -> INIT first cycle with reset=0.
//   INIT: no pops; -> IDLE when init=0 and dst_push=0 (in-flight push done).
//   IDLE -> ACTIVE when any (src_mask & ~src_empty); ACTIVE -> IDLE when none and dst_push=0.
//   IDLE/ACTIVE -> INIT when init=1 (takes priority over IDLE/ACTIVE moves).
//   any state except RESET -> ERROR when |src_error or dst_error or (dst_push and dst_full).
//   ERROR sticky: src_pop=0, dst_push=0 next cycle; exits only via reset. ERROR beats init.
//  Grant (evaluated combinationally, registered into src_pop):
//   eligible = src_mask & ~src_empty; pop allowed only if state==ACTIVE, no error condition,
//   dst_afull=0, dst_full=0. Granted index = first eligible after rr_ptr, cyclic wrap N_REQ-1->0.
//   On grant: src_pop one-hot at next edge; rr_ptr <= granted index. No grant -> rr_ptr holds.
//  Latency: src_pop high in cycle t; source data_out valid in t+1; dst_push=1 and
//   grant_id=index in t+1 (dst_push is src_pop delayed one cycle). Throughput 1 word/cycle.
//  Backpressure: afull (not full) stops pops so the single in-flight word always fits;
//   push already scheduled completes even if afull rises.
//  Source flags update on the same edge as the pop, so back-to-back pops of one source
//   never underflow; single remaining eligible source may be popped every cycle.
//  Masked source with data is never granted; unmasking takes effect next grant evaluation.
//  Reset mid-operation: dropped in-flight push is allowed (FIFOs reset together).
// TESTING
//  1 reset 2 cycles, all empty -> RESET,INIT,IDLE; src_pop=0, dst_push=0, grant_id=0.
//  2 src0..3 each hold 2 words, mask=4'hF, dst empty -> pop order 0,1,2,3,0,1,2,3,
//    pushes one cycle later, 8 words in dst, then IDLE.
//  3 only src2 has 3 words -> src_pop=4'b0100 three consecutive cycles, dst gets 3 words in order.
//  4 dst_afull rises mid-stream -> pops stop next cycle, pending push completes, resume
//    at next rr index after afull falls; no word lost or duplicated.
//  5 src1 masked with data, others empty -> no pop; unmask -> src1 popped next cycle.
//  6 src_error[3]=1 in ACTIVE -> state=4, error_out=1, no further pops; init=1 ignored until reset.

Source files
------------

// File: rtl/fifo_rr_arbiter.sv
// Round-robin scheduler draining N_REQ source FIFOs into one destination FIFO, one word per cycle.
// Source pops are registered; the destination push follows each pop by exactly one cycle.
module fifo_rr_arbiter #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ID_W   = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    init_i,
  input  logic [N_REQ-1:0]        src_mask_i,
  input  logic [N_REQ-1:0]        src_empty_i,
  input  logic [N_REQ-1:0]        src_error_i,
  input  logic [N_REQ*DATA_W-1:0] src_data_i,
  output logic [N_REQ-1:0]        src_pop_o,
  input  logic                    dst_full_i,
  input  logic                    dst_afull_i,
  input  logic                    dst_error_i,
  output logic                    dst_push_o,
  output logic [DATA_W-1:0]       dst_data_o,
  output logic [ID_W-1:0]         grant_id_o,
  output logic [2:0]              state_o,
  output logic                    idle_o,
  output logic                    error_out_o
);

  typedef enum logic [2:0] {
    StReset  = 3'd0,
    StInit   = 3'd1,
    StIdle   = 3'd2,
    StActive = 3'd3,
    StError  = 3'd4
  } state_e;

  state_e            state_q;
  logic [N_REQ-1:0]  src_pop_q;
  logic [N_REQ-1:0]  src_pop_d;
  logic              dst_push_q;
  logic [ID_W-1:0]   grant_id_q;
  logic [ID_W-1:0]   rr_ptr_q;

  logic [N_REQ-1:0]  eligible;
  logic              any_elig;
  logic              err_cond;
  logic              to_error;
  logic              pop_ok;
  logic              gnt_valid;
  logic [ID_W-1:0]   gnt_idx;
  int unsigned       cand;

  assign eligible = src_mask_i & ~src_empty_i;
  assign any_elig = |eligible;
  assign err_cond = (|src_error_i) | dst_error_i | (dst_push_q & dst_full_i);
  assign to_error = err_cond && (state_q != StReset);
  // Stop on almost_full so the single in-flight word always has room.
  assign pop_ok   = (state_q == StActive) && !err_cond && !dst_afull_i && !dst_full_i;

  // First eligible source strictly after the last granted one, wrapping.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = rr_ptr_q;
    cand      = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(rr_ptr_q) + k) % N_REQ;
      if (!gnt_valid && eligible[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = ID_W'(cand);
      end
    end
    src_pop_d = '0;
    if (pop_ok && gnt_valid) begin
      src_pop_d[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StReset;
      src_pop_q  <= '0;
      dst_push_q <= 1'b0;
      grant_id_q <= '0;
      rr_ptr_q   <= ID_W'(N_REQ - 1);
    end else begin
      src_pop_q  <= src_pop_d;
      dst_push_q <= (|src_pop_q) && !to_error && (state_q != StError);
      if (|src_pop_d) begin
        rr_ptr_q <= gnt_idx;
      end
      // rr_ptr_q still names the source popped this cycle.
      if (|src_pop_q) begin
        grant_id_q <= rr_ptr_q;
      end
      if (to_error) begin
        state_q <= StError;
      end else begin
        case (state_q)
          StReset: state_q <= StInit;
          StInit: begin
            if (!init_i && !dst_push_q) state_q <= StIdle;
          end
          StIdle: begin
            if (init_i)        state_q <= StInit;
            else if (any_elig) state_q <= StActive;
          end
          StActive: begin
            if (init_i)                       state_q <= StInit;
            else if (!any_elig && !dst_push_q) state_q <= StIdle;
          end
          StError: state_q <= StError;
          default: state_q <= StError;
        endcase
      end
    end
  end

  assign src_pop_o   = src_pop_q;
  assign dst_push_o  = dst_push_q;
  assign grant_id_o  = grant_id_q;
  assign dst_data_o  = src_data_i[32'(grant_id_q) * DATA_W +: DATA_W];
  assign state_o     = state_q;
  assign idle_o      = (state_q == StIdle);
  assign error_out_o = (state_q == StError);

endmodule
